// File: rtl/fp_conv_reg_pkg.sv
// Shared helpers for the floating-point format converters: biases, integer
// min/max/abs, and field extraction for an arbitrary {sign, exp, mant} layout.
package fp_pkg;

   localparam int FP_MAXW      = 128;
   localparam int EXP_ONES_F16 = 31;
   localparam int EXP_ONES_F32 = 255;
   localparam int EXP_ONES_F64 = 2047;

   function automatic int BIAS(input int nx);
      return (1 << (nx - 1)) - 1;
   endfunction

   function automatic int MIN(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int MAX(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int FABS(input int a);
      return (a < 0) ? -a : a;
   endfunction

   function automatic int exp_ones(input int nx);
      return (1 << nx) - 1;
   endfunction

   // Callers zero-extend their word to FP_MAXW bits before extraction.
   function automatic logic fp_sign(input logic [FP_MAXW-1:0] w, input int nx, input int nm);
      return |(w & (FP_MAXW'(1) << (nx + nm)));
   endfunction

   function automatic logic [31:0] fp_exp(input logic [FP_MAXW-1:0] w, input int nx, input int nm);
      return 32'((w >> nm) & ((FP_MAXW'(1) << nx) - FP_MAXW'(1)));
   endfunction

   function automatic logic [FP_MAXW-1:0] fp_mant(input logic [FP_MAXW-1:0] w, input int nm);
      return w & ((FP_MAXW'(1) << nm) - FP_MAXW'(1));
   endfunction

endpackage

// File: rtl/fp_conv_reg_clz.sv
// Count-leading-zeros as a recursive halving tree; clz(0) == N.
module clz_n #(
   parameter int N = 32
) (
   input  logic [N-1:0]             in_vec,
   output logic [$clog2(N+1)-1:0]   lz
);

   localparam int W = $clog2(N + 1);

   generate
      if (N == 1) begin : g_leaf
         always_comb lz = W'(~in_vec[0]);
      end else begin : g_split
         localparam int NH = (N + 1) / 2;
         localparam int NL = N - NH;
         localparam int WH = $clog2(NH + 1);
         localparam int WL = $clog2(NL + 1);

         logic [WH-1:0] lz_hi;
         logic [WL-1:0] lz_lo;

         clz_n #(.N(NH)) u_hi (
            .in_vec (in_vec[N-1 -: NH]),
            .lz     (lz_hi)
         );

         clz_n #(.N(NL)) u_lo (
            .in_vec (in_vec[NL-1:0]),
            .lz     (lz_lo)
         );

         // Upper half entirely zero: count continues into the lower half.
         always_comb begin
            if (lz_hi == WH'(NH)) lz = W'(NH) + W'(lz_lo);
            else                  lz = W'(lz_hi);
         end
      end
   endgenerate

endmodule

// File: rtl/fp_conv_reg.sv
// Registered IEEE-style format converter: {sign, NX exp, NM mant} to
// {sign, ONX exp, ONM mant}, round-to-nearest-even, one register stage.
module fp_conv_reg
   import fp_pkg::*;
#(
   parameter int NX  = 8,
   parameter int NM  = 23,
   parameter int ONX = 8,
   parameter int ONM = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [NX+NM:0]       in_fp,
   output logic                 out_valid,
   output logic [ONX+ONM:0]     out_fp,
   output logic                 out_inexact
);

   localparam int OW       = 1 + ONX + ONM;
   localparam int BIAS_IN  = BIAS(NX);
   localparam int BIAS_OUT = BIAS(ONX);
   localparam int EMAX_OUT = exp_ones(ONX);
   localparam int LZW      = $clog2(NM + 1);
   localparam int MW       = MAX(NM, ONM);
   localparam int SW       = MW + 1;
   localparam int SH       = ONM + 2;
   localparam int WW       = SW + SH;

   logic              sign_in;
   logic [NX-1:0]     exp_in;
   logic [NM-1:0]     mant_in;
   logic [LZW-1:0]    lz;

   logic              exp_zero;
   logic              exp_max;
   logic              mant_zero;
   logic [NM-1:0]     norm_frac;
   logic signed [31:0] e_unb;
   logic signed [31:0] e_out;
   logic [SW-1:0]     sig_ext;
   logic [31:0]       sh;
   logic [WW-1:0]     shifted;
   logic [ONM:0]      rnd_keep;
   logic              guard;
   logic              sticky;
   logic              round_up;
   logic              lossy;
   logic [ONM+1:0]    rnd_sum;
   logic [MW-1:0]     m_al;
   logic [ONM-1:0]    nan_mant;

   logic              res_sign;
   logic [ONX-1:0]    res_exp;
   logic [ONM-1:0]    res_mant;
   logic              res_inexact;

   logic              valid_d,   valid_q;
   logic [OW-1:0]     fp_d,      fp_q;
   logic              inexact_d, inexact_q;

   assign sign_in = fp_sign(FP_MAXW'(in_fp), NX, NM);
   assign exp_in  = NX'(fp_exp(FP_MAXW'(in_fp), NX, NM));
   assign mant_in = NM'(fp_mant(FP_MAXW'(in_fp), NM));

   clz_n #(.N(NM)) u_clz (
      .in_vec (mant_in),
      .lz     (lz)
   );

   // Normalise, align to the output precision, round.
   always_comb begin
      exp_zero  = (exp_in == '0);
      exp_max   = (exp_in == '1);
      mant_zero = (mant_in == '0);

      norm_frac = mant_in;
      e_unb     = $signed(32'(exp_in)) - BIAS_IN;
      if (exp_zero) begin
         // Subnormal: leading 1 becomes the hidden bit; 1 - bias - (lz + 1).
         norm_frac = mant_in << (32'(lz) + 32'd1);
         e_unb     = -BIAS_IN - $signed(32'(lz));
      end

      sig_ext = SW'({1'b1, norm_frac}) << (SW - 1 - NM);
      e_out   = e_unb + BIAS_OUT;

      // Shifts past ONM+2 leave only sticky bits, so clamping is lossless.
      sh = '0;
      if (e_out <= 0) sh = 32'(MIN(FABS(e_out) + 1, SH));
      shifted = {sig_ext, {SH{1'b0}}} >> sh;

      rnd_keep = shifted[WW-1 -: ONM+1];
      guard    = shifted[SW];
      sticky   = |shifted[SW-1:0];
      round_up = guard & (sticky | rnd_keep[0]);
      lossy    = guard | sticky;
      rnd_sum  = {1'b0, rnd_keep} + (ONM+2)'(round_up);

      m_al     = MW'(mant_in) << (MW - NM);
      nan_mant = m_al[MW-1 -: ONM];
      if (nan_mant == '0) nan_mant[ONM-1] = 1'b1;
   end

   always_comb begin
      res_sign    = sign_in;
      res_exp     = '0;
      res_mant    = '0;
      res_inexact = 1'b0;
      if (exp_max) begin
         res_exp = '1;
         if (!mant_zero) res_mant = nan_mant;
      end else if (exp_zero && mant_zero) begin
         res_exp = '0;
      end else if (e_out >= EMAX_OUT) begin
         res_exp     = '1;
         res_inexact = 1'b1;
      end else if (e_out >= 1) begin
         // A carry into EMAX_OUT leaves a zero fraction, which is exactly Inf.
         res_exp     = ONX'(e_out + $signed(32'(rnd_sum[ONM+1])));
         res_mant    = rnd_sum[ONM-1:0];
         res_inexact = lossy;
      end else begin
         res_exp     = ONX'(rnd_sum[ONM]);
         res_mant    = rnd_sum[ONM-1:0];
         res_inexact = lossy;
      end
   end

   always_comb begin
      valid_d   = in_valid;
      fp_d      = fp_q;
      inexact_d = inexact_q;
      if (in_valid) begin
         fp_d      = {res_sign, res_exp, res_mant};
         inexact_d = res_inexact;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         fp_q      <= '0;
         inexact_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         fp_q      <= fp_d;
         inexact_q <= inexact_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_fp      = fp_q;
   assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp_conv_reg.sv
// Directed and random checks of fp_conv_reg in widen, narrow, round-trip and
// identity configurations, plus the clz_n leading-zero counter.
module tb_fp_conv_reg;

   typedef struct {
      logic [63:0] fp;
      logic        ix;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        w_iv = 1'b0, n_iv = 1'b0, rt_iv = 1'b0, id_iv = 1'b0;
   logic [31:0] w_in = '0, rt_in = '0, id_in = '0;
   logic [63:0] n_in = '0;
   logic        w_ov, n_ov, rtm_ov, rt_ov, id_ov;
   logic [63:0] w_out, rtm_out;
   logic [31:0] n_out, rt_out, id_out;
   logic        w_ix, n_ix, rtm_ix, rt_ix, id_ix;
   logic [31:0] clz_in = '0;
   logic [5:0]  clz_out;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   exp_t sb_q [4][$];

   logic [31:0] w_tab_in  [8] = '{32'h3F800000, 32'hC0490FDB, 32'h00000001, 32'h80000000,
                                  32'h7F800000, 32'h7FC00001, 32'h807FFFFF, 32'h7F7FFFFF};
   logic [63:0] w_tab_exp [8] = '{64'h3FF0000000000000, 64'hC00921FB60000000,
                                  64'h36A0000000000000, 64'h8000000000000000,
                                  64'h7FF0000000000000, 64'h7FF8000020000000,
                                  64'hB80FFFFFC0000000, 64'h47EFFFFFE0000000};

   logic [63:0] n_tab_in  [16] = '{64'h3FF0000010000000, 64'h3FF0000030000000,
                                   64'h7E37E43C8800759C, 64'h3690000000000000,
                                   64'h7FF8000000000001, 64'h7FF0000000000001,
                                   64'h36A0000000000000, 64'h380FFFFFFFFFFFFF,
                                   64'h47EFFFFFE0000000, 64'h47EFFFFFF0000000,
                                   64'hBFF0000000000001, 64'h8000000000000000,
                                   64'hFFF0000000000000, 64'h0000000000000001,
                                   64'h36A8000000000000, 64'h3FF0000010000001};
   logic [31:0] n_tab_exp [16] = '{32'h3F800000, 32'h3F800002, 32'h7F800000, 32'h00000000,
                                   32'h7FC00000, 32'h7FC00000, 32'h00000001, 32'h00800000,
                                   32'h7F7FFFFF, 32'h7F800000, 32'hBF800000, 32'h80000000,
                                   32'hFF800000, 32'h00000000, 32'h00000002, 32'h3F800001};
   logic        n_tab_ix  [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   fp_conv_reg #(.NX(8), .NM(23), .ONX(11), .ONM(52)) u_wide (
      .clk(clk), .rst(rst), .in_valid(w_iv), .in_fp(w_in),
      .out_valid(w_ov), .out_fp(w_out), .out_inexact(w_ix));

   fp_conv_reg #(.NX(11), .NM(52), .ONX(8), .ONM(23)) u_narrow (
      .clk(clk), .rst(rst), .in_valid(n_iv), .in_fp(n_in),
      .out_valid(n_ov), .out_fp(n_out), .out_inexact(n_ix));

   fp_conv_reg #(.NX(8), .NM(23), .ONX(11), .ONM(52)) u_rt_w (
      .clk(clk), .rst(rst), .in_valid(rt_iv), .in_fp(rt_in),
      .out_valid(rtm_ov), .out_fp(rtm_out), .out_inexact(rtm_ix));

   fp_conv_reg #(.NX(11), .NM(52), .ONX(8), .ONM(23)) u_rt_n (
      .clk(clk), .rst(rst), .in_valid(rtm_ov), .in_fp(rtm_out),
      .out_valid(rt_ov), .out_fp(rt_out), .out_inexact(rt_ix));

   fp_conv_reg #(.NX(8), .NM(23), .ONX(8), .ONM(23)) u_id (
      .clk(clk), .rst(rst), .in_valid(id_iv), .in_fp(id_in),
      .out_valid(id_ov), .out_fp(id_out), .out_inexact(id_ix));

   clz_n #(.N(32)) u_clz32 (
      .in_vec (clz_in),
      .lz     (clz_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push(input int k, input logic [63:0] fp, input logic ix, input int lat);
      exp_t e;
      e.fp  = fp;
      e.ix  = ix;
      e.due = cyc + lat;
      sb_q[k].push_back(e);
   endtask

   task automatic sb_check(input int k, input string tag, input logic ov,
                           input logic [63:0] fp, input logic ix);
      exp_t e;
      logic want;
      want = (sb_q[k].size() != 0) && (sb_q[k][0].due == cyc);
      chk({tag, "_valid"}, 64'(ov), 64'(want));
      if (want) begin
         e = sb_q[k].pop_front();
         if (ov) begin
            chk({tag, "_fp"}, fp, e.fp);
            chk({tag, "_inexact"}, 64'(ix), 64'(e.ix));
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      sb_check(0, "wide",   w_ov,  w_out,        w_ix);
      sb_check(1, "narrow", n_ov,  64'(n_out),   n_ix);
      sb_check(2, "rtrip",  rt_ov, 64'(rt_out),  rt_ix);
      sb_check(3, "ident",  id_ov, 64'(id_out),  id_ix);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] x, y;

      for (int i = 0; i < 32; i++) begin
         clz_in = 32'd1 << i;
         #1;
         chk("clz_onehot", 64'(clz_out), 64'(31 - i));
      end
      clz_in = 32'h0;
      #1;
      chk("clz_zero", 64'(clz_out), 64'd32);
      clz_in = 32'hFFFFFFFF;
      #1;
      chk("clz_ones", 64'(clz_out), 64'd0);

      tick();
      tick();
      chk("reset_wide_fp",   w_out,       64'h0);
      chk("reset_wide_ix",   64'(w_ix),   64'h0);
      chk("reset_narrow_fp", 64'(n_out),  64'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         w_iv = 1'b1;
         w_in = w_tab_in[i];
         push(0, w_tab_exp[i], 1'b0, 1);
         tick();
      end
      w_iv = 1'b0;
      w_in = 32'h12345678;
      tick();
      chk("wide_hold_fp", w_out,     w_tab_exp[7]);
      chk("wide_hold_ix", 64'(w_ix), 64'h0);

      for (int i = 0; i < 16; i++) begin
         n_iv = 1'b1;
         n_in = n_tab_in[i];
         push(1, 64'(n_tab_exp[i]), n_tab_ix[i], 1);
         tick();
      end
      n_iv = 1'b0;
      tick();

      w_iv = 1'b1;
      w_in = 32'h40000000;
      push(0, 64'h4000000000000000, 1'b0, 1);
      tick();
      w_in = 32'h3F800000;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(w_ov), 64'h0);
      chk("rst_async_fp",    w_out,     64'h0);
      for (int k = 0; k < 4; k++) sb_q[k].delete();
      tick();
      chk("rst_held_fp", w_out, 64'h0);
      rst = 1'b0;
      push(0, 64'h3FF0000000000000, 1'b0, 1);
      tick();
      w_iv = 1'b0;
      tick();

      for (int i = 0; i < 1500; i++) begin
         x = $urandom;
         if ($urandom_range(0, 7) == 0) x[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
         if (x[30:23] == 8'hFF) x[22:0] = '0;
         y = $urandom;
         if ($urandom_range(0, 7) == 0) y[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
         rt_iv = ($urandom_range(0, 3) != 0);
         rt_in = x;
         if (rt_iv) push(2, 64'(x), 1'b0, 2);
         id_iv = 1'b1;
         id_in = y;
         push(3, 64'(y), 1'b0, 1);
         tick();
      end
      rt_iv = 1'b0;
      id_iv = 1'b0;
      repeat (3) tick();

      chk("drain_wide",   64'(sb_q[0].size()), 64'h0);
      chk("drain_narrow", 64'(sb_q[1].size()), 64'h0);
      chk("drain_rtrip",  64'(sb_q[2].size()), 64'h0);
      chk("drain_ident",  64'(sb_q[3].size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
